// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit CPU datapath.
// Optional macro CTRL_ILLEGAL_TRAP_EN: opcode 0xB traps to HALT with illegal set (otherwise a NOP).
module cpu_ctrl_fsm #(
    parameter int PC_W   = 4,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [15:0]       imem_data,
    input  logic              imem_valid,
    input  logic              rn_eq,
    output logic [PC_W-1:0]   pc,
    output logic [15:0]       ir,
    output logic [2:0]        alu_sel,
    output logic              alu_b_imm,
    output logic              alu_a_zero,
    output logic              en_alu,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [REG_AW-1:0] rf_raddr_a,
    output logic [REG_AW-1:0] rf_raddr_b,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [3:0]        mem_addr,
    output logic              halted,
    output logic              illegal
);

    localparam logic [3:0] OP_HALT = 4'h9;
    localparam logic [3:0] OP_RSVD = 4'hB;
    localparam logic [3:0] OP_BEQ  = 4'hC;
    localparam logic [3:0] OP_B    = 4'hD;
    localparam logic [3:0] OP_STUR = 4'hE;
    localparam logic [3:0] OP_LDUR = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef struct packed {
        logic [2:0]        alu_sel;
        logic              alu_b_imm;
        logic              alu_a_zero;
        logic              en_alu;
        logic              rf_we;
        logic [REG_AW-1:0] rf_waddr;
        logic [REG_AW-1:0] rf_raddr_a;
        logic [REG_AW-1:0] rf_raddr_b;
        logic              mem_we;
        logic              mem_oe;
        logic [3:0]        mem_addr;
        logic              halted;
    } ctrl_t;

    function automatic logic is_alu(input logic [3:0] op);
        return (op <= 4'h8) || (op == 4'hA);
    endfunction

    function automatic logic [2:0] alu_fn(input logic [3:0] op);
        case (op)
            4'h0, 4'h1: alu_fn = 3'b000;
            4'h2, 4'h3: alu_fn = 3'b001;
            4'h4:       alu_fn = 3'b010;
            4'h5:       alu_fn = 3'b011;
            4'h6:       alu_fn = 3'b100;
            4'h7:       alu_fn = 3'b101;
            4'h8:       alu_fn = 3'b110;
            4'hA:       alu_fn = 3'b111;
            default:    alu_fn = 3'b000;
        endcase
    endfunction

    state_t          r_state, w_state_next;
    logic [15:0]     r_ir;
    logic [PC_W-1:0] r_pc, w_pc_next, w_pc_inc, w_rd_pc;
    ctrl_t           r_ctl, w_ctl;
    logic [15:0]     w_instr;
    logic [3:0]      w_op, w_nop;

    // Outputs are decoded from the next state, so the instruction being latched this edge must be used.
    assign w_instr  = (r_state == S_FETCH) ? imem_data : r_ir;
    assign w_op     = r_ir[15:12];
    assign w_nop    = w_instr[15:12];
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_rd_pc  = PC_W'(r_ir[11:8]);

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            S_IDLE:   if (run) w_state_next = S_FETCH;
            S_FETCH: begin
                if (imem_valid)  w_state_next = S_DECODE;
                else if (!run)   w_state_next = S_IDLE;
            end
            S_DECODE: begin
                case (w_op)
                    OP_HALT: w_state_next = S_HALT;
                    OP_LDUR: w_state_next = S_MEM;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    OP_RSVD: w_state_next = S_HALT;
`else
                    OP_RSVD: begin
                        w_state_next = S_FETCH;
                        w_pc_next    = w_pc_inc;
                    end
`endif
                    default: w_state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (w_op == OP_STUR) begin
                    w_state_next = S_MEM;
                end else if (w_op == OP_BEQ) begin
                    w_state_next = S_FETCH;
                    w_pc_next    = rn_eq ? (r_pc + w_rd_pc) : w_pc_inc;
                end else if (w_op == OP_B) begin
                    w_state_next = S_FETCH;
                    w_pc_next    = r_pc - w_rd_pc;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                if (w_op == OP_LDUR) begin
                    w_state_next = S_WB;
                end else begin
                    w_state_next = S_FETCH;
                    w_pc_next    = w_pc_inc;
                end
            end
            S_WB: begin
                w_state_next = S_FETCH;
                w_pc_next    = w_pc_inc;
            end
            S_HALT:   w_state_next = S_HALT;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ctl = '0;
        case (w_state_next)
            S_DECODE: begin
                w_ctl.rf_raddr_a = REG_AW'(w_instr[7:4]);
                w_ctl.rf_raddr_b = REG_AW'(w_instr[3:0]);
            end
            S_EXEC: begin
                w_ctl.rf_raddr_a = REG_AW'(w_instr[7:4]);
                w_ctl.rf_raddr_b = REG_AW'(w_instr[3:0]);
                if (w_nop == OP_STUR) begin
                    // Store passes Rx[Rn] through the ALU as 0 + B.
                    w_ctl.rf_raddr_b = REG_AW'(w_instr[7:4]);
                    w_ctl.alu_a_zero = 1'b1;
                    w_ctl.en_alu     = 1'b1;
                end else if (is_alu(w_nop)) begin
                    w_ctl.alu_sel    = alu_fn(w_nop);
                    w_ctl.alu_b_imm  = (w_nop == 4'h1) || (w_nop == 4'h3) || (w_nop == 4'hA);
                    w_ctl.en_alu     = 1'b1;
                end
            end
            S_MEM: begin
                w_ctl.mem_addr = w_instr[11:8];
                if (w_nop == OP_STUR) begin
                    w_ctl.rf_raddr_a = REG_AW'(w_instr[7:4]);
                    w_ctl.rf_raddr_b = REG_AW'(w_instr[7:4]);
                    w_ctl.alu_a_zero = 1'b1;
                    w_ctl.en_alu     = 1'b1;
                    w_ctl.mem_we     = 1'b1;
                end else begin
                    w_ctl.mem_oe     = 1'b1;
                end
            end
            S_WB: begin
                w_ctl.rf_we = 1'b1;
                if (w_nop == OP_LDUR) begin
                    w_ctl.mem_oe   = 1'b1;
                    w_ctl.mem_addr = w_instr[11:8];
                    w_ctl.rf_waddr = REG_AW'(w_instr[7:4]);
                end else begin
                    w_ctl.rf_raddr_a = REG_AW'(w_instr[7:4]);
                    w_ctl.rf_raddr_b = REG_AW'(w_instr[3:0]);
                    w_ctl.alu_sel    = alu_fn(w_nop);
                    w_ctl.alu_b_imm  = (w_nop == 4'h1) || (w_nop == 4'h3) || (w_nop == 4'hA);
                    w_ctl.en_alu     = 1'b1;
                    w_ctl.rf_waddr   = REG_AW'(w_instr[11:8]);
                end
            end
            S_HALT:   w_ctl.halted = 1'b1;
            default:  w_ctl = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; ir is reset too since it is a visible output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_ctl   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_ctl   <= w_ctl;
            if (r_state == S_FETCH && imem_valid) r_ir <= imem_data;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
    logic w_illegal;
    assign w_illegal = (w_state_next == S_HALT) && (w_nop == OP_RSVD);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_illegal <= 1'b0;
        else     r_illegal <= w_illegal;
    end
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    assign pc         = r_pc;
    assign ir         = r_ir;
    assign alu_sel    = r_ctl.alu_sel;
    assign alu_b_imm  = r_ctl.alu_b_imm;
    assign alu_a_zero = r_ctl.alu_a_zero;
    assign en_alu     = r_ctl.en_alu;
    assign rf_we      = r_ctl.rf_we;
    assign rf_waddr   = r_ctl.rf_waddr;
    assign rf_raddr_a = r_ctl.rf_raddr_a;
    assign rf_raddr_b = r_ctl.rf_raddr_b;
    assign mem_we     = r_ctl.mem_we;
    assign mem_oe     = r_ctl.mem_oe;
    assign mem_addr   = r_ctl.mem_addr;
    assign halted     = r_ctl.halted;

    a_bus_excl: assert property (@(posedge clk) disable iff (rst) !(r_ctl.en_alu && r_ctl.mem_oe));

endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control unit that sequences the 16-bit CPU datapath.
- Owns the PC and the instruction register (IR), and runs each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the ALU select, the ALU-to-bus buffer enable, register-file and RAM strobes, and branch control.
- Replaces the ad-hoc clock-edge sequencing in the CPU top level.

Parameters:
- PC_W, 4, program counter / instruction memory address width.
- REG_AW, 4, register-file address width (matches the 4-bit Rd/Rn/Rm fields).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; FSM leaves IDLE while high.
- imem_data  in  16  instruction word at address pc.
- imem_valid  in  1  imem_data valid this cycle.
- rn_eq  in  1  datapath compare result, Rx[Rn] == zero-extended Rm; sampled in EXEC.
- pc  out  PC_W  current instruction address.
- ir  out  16  latched instruction.
- alu_sel  out  3  ALU function select.
- alu_b_imm  out  1  ALU B operand = zero-extended Rm, else Rx[Rm].
- alu_a_zero  out  1  ALU A operand forced to 0 (store pass-through).
- en_alu  out  1  ALU buffer drives the bus.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  REG_AW  register write address.
- rf_raddr_a  out  REG_AW  register read address A (Rn).
- rf_raddr_b  out  REG_AW  register read address B (Rm).
- mem_we  out  1  RAM write.
- mem_oe  out  1  RAM output enable.
- mem_addr  out  4  RAM address (Rd field).
- halted  out  1  HALT executed.
- illegal  out  1  illegal opcode trapped (optional feature only).

Behaviour:
- Instruction fields: opcode = ir[15:12], Rd = ir[11:8], Rn = ir[7:4], Rm = ir[3:0].
- Reset (asynchronous, any state, including mid-instruction):
  - state = IDLE, pc = 0, ir = 0.
  - All strobes 0: en_alu, rf_we, mem_we, mem_oe.
  - alu_sel = 0, alu_b_imm = 0, alu_a_zero = 0, halted = 0, illegal = 0.
  - Address outputs = 0.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. All outputs are registered, decoded from the next state.
- IDLE -> FETCH when run = 1.
- FETCH:
  - Holds until imem_valid = 1.
  - Then ir <= imem_data, go to DECODE.
  - If run drops while waiting: return to IDLE.
- DECODE:
  - rf_raddr_a = Rn, rf_raddr_b = Rm.
  - Branch on opcode.
- ALU ops (0 ADD, 1 ADDI, 2 SUB, 3 SUBI, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 NAND, A LSL):
  - EXEC: alu_sel = 000/000/001/001/010/011/100/101/110/111; alu_b_imm = 1 for ADDI, SUBI, LSL; en_alu = 1.
  - WB: en_alu = 1, rf_we = 1, rf_waddr = Rd.
  - Total 4 cycles, FETCH to FETCH, with imem_valid already high.
- STUR (E):
  - EXEC: alu_a_zero = 1, alu_sel = 000, en_alu = 1, rf_raddr_b = Rn.
  - MEM: en_alu = 1, mem_we = 1, mem_oe = 0, mem_addr = Rd.
- LDUR (F):
  - MEM: mem_oe = 1, mem_addr = Rd.
  - WB: mem_oe = 1, rf_we = 1, rf_waddr = Rn.
- BEQ (C):
  - EXEC: if rn_eq, pc <= pc + Rd; else pc <= pc + 1.
  - 3 cycles.
- B (D):
  - EXEC: pc <= pc - Rd.
  - Rd = 0 is a self-loop (legal).
- HALT (9):
  - DECODE -> HALT; halted = 1.
  - Exit only by rst; pc frozen.
- Reserved (B): see Optional Feature.
- PC update:
  - Non-branch instructions: pc <= pc + 1 on the last cycle of the instruction.
  - All PC arithmetic is modulo 2^PC_W; Rd is zero-extended or truncated to PC_W.
- Bus exclusivity: en_alu and mem_oe are never 1 in the same cycle; an implementation assertion enforces this.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: opcode B goes DECODE -> HALT with illegal = 1 and halted = 1; pc keeps the faulting address.
- Undefined: opcode B executes as a 2-cycle NOP (pc + 1); the illegal port is tied 0.

Test Plan:
- Reset: rst pulse mid-EXEC of an ADD -> next cycle all strobes 0, pc = 0, state IDLE, no rf_we seen.
- ALU op: run = 1, imem_valid = 1, instr 0x0312 (ADD R3 = R1 + R2) -> alu_sel = 000, en_alu for 2 cycles, rf_we = 1 with rf_waddr = 3 in cycle 4, pc 0 -> 1.
- Memory: instr 0xE520 (STUR) -> mem_we pulse with mem_addr = 5; then 0xF560 (LDUR) -> mem_oe for 2 cycles, rf_we with rf_waddr = 6; en_alu and mem_oe never both high.
- Branch: at pc = 2, instr 0xC305 with rn_eq = 1 -> pc = 5; with rn_eq = 0 -> pc = 3; at pc = 1, instr 0xD300 -> pc = 14 (wrap).
- Stall and halt:
  - imem_valid held low 3 cycles in FETCH -> ir unchanged, no strobes.
  - Instr 0x9000 -> halted = 1, pc frozen, stays halted until rst.
- Reserved opcode: instr 0xB000 -> with CTRL_ILLEGAL_TRAP_EN, illegal = 1 and halted = 1; without it, pc advances by 1 and no strobes fire.
